// File: rtl/seg_memory.sv
// rtl/seg_memory.sv - MEM stage of the 5-stage MIPS pipeline (EX/MEM latch, data memory, MEM/WB latch)
//
// Purpose:
//   Latches the execute-stage results, resolves conditional branches, performs
//   word-addressed synchronous loads/stores and forwards results to write-back.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_enable              stage advance; 0 holds both latches and blocks writes
//   i_flush               EX/MEM captures a bubble (control bits forced to 0)
//   i_PC_branch ..        execute-stage datapath and control inputs
//   o_PC_branch, o_PCSrc  latched branch target and branch-taken decision
//   o_read_data ..        MEM/WB outputs toward write-back
//   o_misaligned          sticky misaligned load/store flag
//
// Optional feature (macro SEG_MEMORY_DEBUG_PORT_EN):
//   i_dbg_addr / o_dbg_data, a second synchronous read-first read port that
//   runs regardless of i_enable so the memory can be dumped while halted.

module seg_memory #(
  parameter int LEN          = 32,
  parameter int NB_ADDR      = 5,
  parameter int NB_DMEM_ADDR = 10,
  parameter int NB_CTRL_WB   = 2,
  parameter int NB_CTRL_M    = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_flush,
  input  logic [LEN-1:0]          i_PC_branch,
  input  logic [LEN-1:0]          i_ALU_result,
  input  logic                    i_ALU_zero,
  input  logic [LEN-1:0]          i_write_data,
  input  logic [NB_ADDR-1:0]      i_write_register,
  input  logic [NB_CTRL_WB-1:0]   i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]    i_ctrl_mem_bus,
`ifdef SEG_MEMORY_DEBUG_PORT_EN
  input  logic [NB_DMEM_ADDR-1:0] i_dbg_addr,
  output logic [LEN-1:0]          o_dbg_data,
`endif
  output logic [LEN-1:0]          o_PC_branch,
  output logic                    o_PCSrc,
  output logic [LEN-1:0]          o_read_data,
  output logic [LEN-1:0]          o_ALU_result,
  output logic [NB_ADDR-1:0]      o_write_register,
  output logic [NB_CTRL_WB-1:0]   o_ctrl_wb_bus,
  output logic                    o_misaligned
);

  localparam int MEM_DEPTH = 1 << NB_DMEM_ADDR;

  // EX/MEM latch
  logic [LEN-1:0]        exm_pc_branch;
  logic [LEN-1:0]        exm_alu_result;
  logic                  exm_zero;
  logic [LEN-1:0]        exm_write_data;
  logic [NB_ADDR-1:0]    exm_write_register;
  logic [NB_CTRL_WB-1:0] exm_ctrl_wb;
  logic [NB_CTRL_M-1:0]  exm_ctrl_mem;

  logic [LEN-1:0] dmem [MEM_DEPTH];

  logic                    mem_read;
  logic                    mem_write;
  logic                    branch;
  logic [NB_DMEM_ADDR-1:0] word_idx;
  logic                    misaligned_now;

  assign mem_read  = exm_ctrl_mem[2];
  assign mem_write = exm_ctrl_mem[1];
  assign branch    = exm_ctrl_mem[0];

  // Byte address -> word index; upper address bits are dropped so accesses wrap.
  assign word_idx       = exm_alu_result[NB_DMEM_ADDR+1:2];
  assign misaligned_now = (exm_alu_result[1:0] != 2'b00) && (mem_read || mem_write);

  assign o_PCSrc     = branch & exm_zero;
  assign o_PC_branch = exm_pc_branch;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      exm_pc_branch      <= '0;
      exm_alu_result     <= '0;
      exm_zero           <= 1'b0;
      exm_write_data     <= '0;
      exm_write_register <= '0;
      exm_ctrl_wb        <= '0;
      exm_ctrl_mem       <= '0;
    end else if (i_enable) begin
      exm_pc_branch      <= i_PC_branch;
      exm_alu_result     <= i_ALU_result;
      exm_zero           <= i_ALU_zero;
      exm_write_data     <= i_write_data;
      exm_write_register <= i_write_register;
      // A flushed slot keeps its data but can no longer write, branch or load.
      exm_ctrl_wb        <= i_flush ? '0 : i_ctrl_wb_bus;
      exm_ctrl_mem       <= i_flush ? '0 : i_ctrl_mem_bus;
    end
  end

  // Data memory has no reset; a store still in EX/MEM when reset hits is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_enable && mem_write) begin
      dmem[word_idx] <= exm_write_data;
    end
  end

  // MEM/WB latch. The read samples dmem before this edge's write lands, so a
  // simultaneous read+write returns the old word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_read_data      <= '0;
      o_ALU_result     <= '0;
      o_write_register <= '0;
      o_ctrl_wb_bus    <= '0;
      o_misaligned     <= 1'b0;
    end else if (i_enable) begin
      o_read_data      <= mem_read ? dmem[word_idx] : '0;
      o_ALU_result     <= exm_alu_result;
      o_write_register <= exm_write_register;
      o_ctrl_wb_bus    <= exm_ctrl_wb;
      if (misaligned_now) begin
        o_misaligned <= 1'b1;
      end
    end
  end

`ifdef SEG_MEMORY_DEBUG_PORT_EN
  always_ff @(posedge i_clk) begin
    o_dbg_data <= dmem[i_dbg_addr];
  end
`endif

endmodule

// File: tb/tb_seg_memory.sv
// tb/tb_seg_memory.sv - directed self-checking bench for seg_memory

module tb_seg_memory;

  localparam int LEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_enable;
  logic            i_flush;
  logic [LEN-1:0]  i_PC_branch;
  logic [LEN-1:0]  i_ALU_result;
  logic            i_ALU_zero;
  logic [LEN-1:0]  i_write_data;
  logic [4:0]      i_write_register;
  logic [1:0]      i_ctrl_wb_bus;
  logic [2:0]      i_ctrl_mem_bus;
  logic [LEN-1:0]  o_PC_branch;
  logic            o_PCSrc;
  logic [LEN-1:0]  o_read_data;
  logic [LEN-1:0]  o_ALU_result;
  logic [4:0]      o_write_register;
  logic [1:0]      o_ctrl_wb_bus;
  logic            o_misaligned;
`ifdef SEG_MEMORY_DEBUG_PORT_EN
  logic [9:0]      i_dbg_addr = '0;
  logic [LEN-1:0]  o_dbg_data;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  seg_memory dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_enable        (i_enable),
    .i_flush         (i_flush),
    .i_PC_branch     (i_PC_branch),
    .i_ALU_result    (i_ALU_result),
    .i_ALU_zero      (i_ALU_zero),
    .i_write_data    (i_write_data),
    .i_write_register(i_write_register),
    .i_ctrl_wb_bus   (i_ctrl_wb_bus),
    .i_ctrl_mem_bus  (i_ctrl_mem_bus),
`ifdef SEG_MEMORY_DEBUG_PORT_EN
    .i_dbg_addr      (i_dbg_addr),
    .o_dbg_data      (o_dbg_data),
`endif
    .o_PC_branch     (o_PC_branch),
    .o_PCSrc         (o_PCSrc),
    .o_read_data     (o_read_data),
    .o_ALU_result    (o_ALU_result),
    .o_write_register(o_write_register),
    .o_ctrl_wb_bus   (o_ctrl_wb_bus),
    .o_misaligned    (o_misaligned)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] mem, input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] wdata, input logic zero, input logic [31:0] pcb,
                       input logic [4:0] wreg);
    i_ctrl_mem_bus   = mem;
    i_ctrl_wb_bus    = wb;
    i_ALU_result     = alu;
    i_write_data     = wdata;
    i_ALU_zero       = zero;
    i_PC_branch      = pcb;
    i_write_register = wreg;
  endtask

  task automatic nop();
    drive(3'b000, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_enable = 1'b1; i_flush = 1'b0; nop();
    step();
    i_rst = 1'b0;
    vectors++;
    if ({o_PC_branch, o_PCSrc, o_read_data, o_ALU_result, o_write_register, o_ctrl_wb_bus, o_misaligned} !== '0) begin
      $display("FAIL reset_outputs: got pcb=%h pcsrc=%b rd=%h alu=%h wr=%h wb=%b mis=%b want all 0",
               o_PC_branch, o_PCSrc, o_read_data, o_ALU_result, o_write_register, o_ctrl_wb_bus, o_misaligned);
      miscompares++;
    end
  endtask

  // SW then LW the very next cycle to the same address (back-to-back forwarding through memory).
  task automatic test_store_load();
    drive(3'b010, 2'b00, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 5'd0); step();
    drive(3'b100, 2'b11, 32'h10, 32'h0, 1'b0, 32'h0, 5'd5);        step();
    nop(); step();
    vectors++;
    if (o_read_data !== 32'hDEADBEEF) begin
      $display("FAIL sw_lw_data: got %h want deadbeef", o_read_data); miscompares++;
    end
    vectors++;
    if (o_ctrl_wb_bus !== 2'b11) begin
      $display("FAIL sw_lw_wb: got %b want 11", o_ctrl_wb_bus); miscompares++;
    end
    vectors++;
    if (o_write_register !== 5'd5 || o_ALU_result !== 32'h10) begin
      $display("FAIL sw_lw_fwd: got wr=%0d alu=%h want wr=5 alu=10", o_write_register, o_ALU_result); miscompares++;
    end
    step();
    vectors++;
    if (o_read_data !== 32'h0) begin
      $display("FAIL nop_read_zero: got %h want 0", o_read_data); miscompares++;
    end
  endtask

  task automatic test_branch();
    drive(3'b001, 2'b00, 32'h0, 32'h0, 1'b1, 32'h40, 5'd0); step();
    vectors++;
    if (o_PCSrc !== 1'b1 || o_PC_branch !== 32'h40) begin
      $display("FAIL branch_taken: got pcsrc=%b pcb=%h want 1 40", o_PCSrc, o_PC_branch); miscompares++;
    end
    drive(3'b001, 2'b00, 32'h4, 32'h0, 1'b0, 32'h40, 5'd0); step();
    vectors++;
    if (o_PCSrc !== 1'b0) begin
      $display("FAIL branch_not_taken: got pcsrc=%b want 0", o_PCSrc); miscompares++;
    end
    nop(); step();
  endtask

  task automatic test_wrap_misaligned();
    drive(3'b010, 2'b00, 32'h1000, 32'hCAFEF00D, 1'b0, 32'h0, 5'd0); step();
    drive(3'b100, 2'b11, 32'h0, 32'h0, 1'b0, 32'h0, 5'd2);           step();
    nop(); step();
    vectors++;
    if (o_read_data !== 32'hCAFEF00D) begin
      $display("FAIL wrap_read: got %h want cafef00d", o_read_data); miscompares++;
    end
    vectors++;
    if (o_misaligned !== 1'b0) begin
      $display("FAIL aligned_no_flag: got %b want 0", o_misaligned); miscompares++;
    end
    drive(3'b100, 2'b11, 32'h2, 32'h0, 1'b0, 32'h0, 5'd2); step();
    nop(); step();
    vectors++;
    if (o_misaligned !== 1'b1 || o_read_data !== 32'hCAFEF00D) begin
      $display("FAIL misaligned_set: got mis=%b rd=%h want 1 cafef00d", o_misaligned, o_read_data); miscompares++;
    end
    step(); step(); step();
    vectors++;
    if (o_misaligned !== 1'b1) begin
      $display("FAIL misaligned_sticky: got %b want 1", o_misaligned); miscompares++;
    end
  endtask

  task automatic test_enable_hold();
    drive(3'b010, 2'b00, 32'h20, 32'h11112222, 1'b0, 32'h0, 5'd0); step();
    drive(3'b001, 2'b00, 32'h44, 32'h0, 1'b1, 32'h80, 5'd3);        step();
    i_enable = 1'b0;
    drive(3'b010, 2'b00, 32'h20, 32'h12345678, 1'b0, 32'h0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (o_PCSrc !== 1'b1 || o_PC_branch !== 32'h80 || o_ALU_result !== 32'h20 || o_ctrl_wb_bus !== 2'b00) begin
        $display("FAIL hold_cycle%0d: got pcsrc=%b pcb=%h alu=%h wb=%b want 1 80 20 00",
                 i, o_PCSrc, o_PC_branch, o_ALU_result, o_ctrl_wb_bus);
        miscompares++;
      end
    end
    i_enable = 1'b1;
    drive(3'b100, 2'b11, 32'h20, 32'h0, 1'b0, 32'h0, 5'd4); step();
    vectors++;
    if (o_ALU_result !== 32'h44) begin
      $display("FAIL hold_release_alu: got %h want 44", o_ALU_result); miscompares++;
    end
    nop(); step();
    vectors++;
    if (o_read_data !== 32'h11112222) begin
      $display("FAIL hold_no_write: got %h want 11112222", o_read_data); miscompares++;
    end
  endtask

  task automatic test_flush();
    drive(3'b010, 2'b00, 32'h30, 32'hAAAA0000, 1'b0, 32'h0, 5'd0); step();
    i_flush = 1'b1;
    drive(3'b011, 2'b11, 32'h30, 32'h55555555, 1'b1, 32'h90, 5'd6); step();
    i_flush = 1'b0;
    vectors++;
    if (o_PCSrc !== 1'b0 || o_PC_branch !== 32'h90) begin
      $display("FAIL flush_branch: got pcsrc=%b pcb=%h want 0 90", o_PCSrc, o_PC_branch); miscompares++;
    end
    drive(3'b100, 2'b11, 32'h30, 32'h0, 1'b0, 32'h0, 5'd6); step();
    vectors++;
    if (o_ctrl_wb_bus !== 2'b00) begin
      $display("FAIL flush_wb: got %b want 00", o_ctrl_wb_bus); miscompares++;
    end
    nop(); step();
    vectors++;
    if (o_read_data !== 32'hAAAA0000) begin
      $display("FAIL flush_no_write: got %h want aaaa0000", o_read_data); miscompares++;
    end
  endtask

  task automatic test_read_first();
    drive(3'b010, 2'b00, 32'h50, 32'h00000001, 1'b0, 32'h0, 5'd0); step();
    drive(3'b110, 2'b00, 32'h50, 32'h00000002, 1'b0, 32'h0, 5'd0); step();
    drive(3'b100, 2'b10, 32'h50, 32'h0, 1'b0, 32'h0, 5'd1);        step();
    vectors++;
    if (o_read_data !== 32'h00000001) begin
      $display("FAIL rw_old_word: got %h want 00000001", o_read_data); miscompares++;
    end
    nop(); step();
    vectors++;
    if (o_read_data !== 32'h00000002) begin
      $display("FAIL rw_write_done: got %h want 00000002", o_read_data); miscompares++;
    end
  endtask

  task automatic test_reset_inflight();
    drive(3'b100, 2'b11, 32'h10, 32'h0, 1'b1, 32'h60, 5'd7); step();
    i_rst = 1'b1; nop(); step();
    i_rst = 1'b0;
    vectors++;
    if ({o_PC_branch, o_PCSrc, o_read_data, o_ALU_result, o_write_register, o_ctrl_wb_bus, o_misaligned} !== '0) begin
      $display("FAIL reset_inflight: got pcb=%h pcsrc=%b rd=%h alu=%h wr=%h wb=%b mis=%b want all 0",
               o_PC_branch, o_PCSrc, o_read_data, o_ALU_result, o_write_register, o_ctrl_wb_bus, o_misaligned);
      miscompares++;
    end
    step();
    vectors++;
    if (o_read_data !== 32'h0 || o_ctrl_wb_bus !== 2'b00) begin
      $display("FAIL reset_dropped_lw: got rd=%h wb=%b want 0 00", o_read_data, o_ctrl_wb_bus); miscompares++;
    end
    drive(3'b100, 2'b11, 32'h10, 32'h0, 1'b0, 32'h0, 5'd7); step();
    nop(); step();
    vectors++;
    if (o_read_data !== 32'hDEADBEEF) begin
      $display("FAIL mem_survives_reset: got %h want deadbeef", o_read_data); miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_branch();
    test_wrap_misaligned();
    test_enable_hold();
    test_flush();
    test_read_first();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
